// File: rtl/fp_alu_arbiter.sv
// fp_alu_arbiter: round-robin sharing of the exp/mult/div/add FP units among NUM_REQ requesters.
// Optional unit watchdog is compiled in with `define FP_ALU_ARB_TIMEOUT_EN.

module fp_alu_arb_unit #(
   parameter int IW             = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          launch,
   input  logic [IW-1:0] launch_owner,
   input  logic          data_ready,
   output logic          busy,
   output logic [IW-1:0] owner,
   output logic          fire,
   output logic          fire_err
);
   logic timeout;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy  <= 1'b0;
         owner <= '0;
      end else if (launch) begin
         busy  <= 1'b1;
         owner <= launch_owner;
      end else if (fire) begin
         busy  <= 1'b0;
      end
   end

`ifdef FP_ALU_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)       cnt <= '0;
      else if (launch) cnt <= '0;
      else if (busy)   cnt <= cnt + 1'b1;
   end

   assign timeout = busy && (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout            = 1'b0;
`endif

   // a real completion beats a watchdog expiry in the same cycle
   assign fire     = busy & (data_ready | timeout);
   assign fire_err = fire & ~data_ready;
endmodule

module fp_alu_arbiter #(
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [3*NUM_REQ-1:0]          req_opcode,
   input  logic [DATA_WIDTH*NUM_REQ-1:0] req_operand_a,
   input  logic [DATA_WIDTH*NUM_REQ-1:0] req_operand_b,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            resp_valid,
   output logic [DATA_WIDTH*NUM_REQ-1:0] resp_result,
   output logic [NUM_REQ-1:0]            resp_err,
   output logic                          exponent_start,
   output logic                          mult_start,
   output logic                          divide_start,
   output logic                          add_start,
   output logic [DATA_WIDTH-1:0]         operand_a,
   output logic [DATA_WIDTH-1:0]         operand_b,
   input  logic [DATA_WIDTH-1:0]         exponent_result,
   input  logic [DATA_WIDTH-1:0]         mult_result,
   input  logic [DATA_WIDTH-1:0]         divide_result,
   input  logic [DATA_WIDTH-1:0]         add_result,
   input  logic                          exponent_data_ready,
   input  logic                          mult_data_ready,
   input  logic                          divide_data_ready,
   input  logic                          add_data_ready
);
   localparam int              IW     = $clog2(NUM_REQ);
   localparam int              NU     = 4;
   localparam logic [2:0]      OP_SUB = 3'b100;
   localparam logic [DATA_WIDTH-1:0] SIGN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic [NU-1:0][DATA_WIDTH-1:0] unit_result;
   logic [NU-1:0]                 unit_ready, unit_busy, unit_fire, unit_fire_err, unit_launch;
   logic [NU-1:0][IW-1:0]         unit_owner;

   logic [NUM_REQ-1:0]            pending, legal, elig;
   logic [NUM_REQ-1:0][2:0]       opc;
   logic [NUM_REQ-1:0][1:0]       unit_sel;

   logic [IW-1:0]                 ptr, gnt_idx;
   logic                          gnt_found;
   logic [IW:0]                   cand;
   logic                          ill_vld;
   logic [IW-1:0]                 ill_idx;

   assign unit_result = {add_result, divide_result, mult_result, exponent_result};
   assign unit_ready  = {add_data_ready, divide_data_ready, mult_data_ready, exponent_data_ready};

   // decode: sub shares the add unit; illegal opcodes never wait on a unit
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         opc[i]      = req_opcode[i*3 +: 3];
         legal[i]    = (opc[i] <= OP_SUB);
         unit_sel[i] = (opc[i] == OP_SUB) ? 2'd3 : opc[i][1:0];
         elig[i]     = req_valid[i] & ~pending[i] & (~legal[i] | ~unit_busy[unit_sel[i]]);
      end
   end

   // round-robin scan starting just after the last grant
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = ptr;
      cand      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = {1'b0, ptr} + (IW+1)'(k);
         if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
         if (!gnt_found && elig[cand[IW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[IW-1:0];
         end
      end
   end

   always_comb begin
      for (int u = 0; u < NU; u++)
         unit_launch[u] = gnt_found & legal[gnt_idx] & (unit_sel[gnt_idx] == 2'(u));
   end

   for (genvar u = 0; u < NU; u++) begin : g_unit
      fp_alu_arb_unit #(
         .IW             (IW),
         .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
      ) u_unit (
         .clock        (clock),
         .reset        (reset),
         .launch       (unit_launch[u]),
         .launch_owner (gnt_idx),
         .data_ready   (unit_ready[u]),
         .busy         (unit_busy[u]),
         .owner        (unit_owner[u]),
         .fire         (unit_fire[u]),
         .fire_err     (unit_fire_err[u])
      );
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr            <= IW'(NUM_REQ - 1);
         pending        <= '0;
         req_ready      <= '0;
         resp_valid     <= '0;
         resp_err       <= '0;
         resp_result    <= '0;
         exponent_start <= 1'b0;
         mult_start     <= 1'b0;
         divide_start   <= 1'b0;
         add_start      <= 1'b0;
         operand_a      <= '0;
         operand_b      <= '0;
         ill_vld        <= 1'b0;
         ill_idx        <= '0;
      end else begin
         req_ready  <= '0;
         resp_valid <= '0;
         resp_err   <= '0;
         ill_vld    <= 1'b0;
         {add_start, divide_start, mult_start, exponent_start} <= unit_launch;

         if (gnt_found) begin
            ptr                <= gnt_idx;
            req_ready[gnt_idx] <= 1'b1;
            pending[gnt_idx]   <= 1'b1;
            if (legal[gnt_idx]) begin
               operand_a <= req_operand_a[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
               operand_b <= req_operand_b[gnt_idx*DATA_WIDTH +: DATA_WIDTH] ^
                            ((opc[gnt_idx] == OP_SUB) ? SIGN : '0);
            end else begin
               ill_vld <= 1'b1;
               ill_idx <= gnt_idx;
            end
         end

         if (ill_vld) begin
            resp_valid[ill_idx]                           <= 1'b1;
            resp_err[ill_idx]                             <= 1'b1;
            resp_result[ill_idx*DATA_WIDTH +: DATA_WIDTH] <= '0;
            pending[ill_idx]                              <= 1'b0;
         end

         // one op per requester, so parallel completions never collide on an owner
         for (int u = 0; u < NU; u++) begin
            if (unit_fire[u]) begin
               resp_valid[unit_owner[u]] <= 1'b1;
               resp_err[unit_owner[u]]   <= unit_fire_err[u];
               resp_result[unit_owner[u]*DATA_WIDTH +: DATA_WIDTH] <=
                  unit_fire_err[u] ? '0 : unit_result[u];
               pending[unit_owner[u]]    <= 1'b0;
            end
         end
      end
   end
endmodule
